// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the RVC boot loader.
// Defining RVC_BOOT_CHECKSUM_EN adds the CSUM state to the state enum.
package rvc_asap_pkg;

    localparam int BOOT_HDR_BYTES = 4;

    typedef enum logic [2:0] {
        HDR,
        DATA,
`ifdef RVC_BOOT_CHECKSUM_EN
        CSUM,
`endif
        WAIT,
        RUN,
        ERR
    } t_boot_state;

endpackage

// File: rtl/rvc_boot_loader_if.sv
// Boot stream input and I_MEM write / core control bundle of the boot loader.
// slave = loader side, master = stream source and memory/core side.
interface rvc_boot_loader_if;

    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        BootRestart;
    logic        ImemWrEn;
    logic [31:0] ImemWrAddr;
    logic [31:0] ImemWrData;
    logic        CoreRst;
    logic        BootDone;
    logic        BootErr;

    modport master (
        output ByteIn, ByteValid, BootRestart,
        input  ByteReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreRst, BootDone, BootErr
    );

    modport slave (
        input  ByteIn, ByteValid, BootRestart,
        output ByteReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreRst, BootDone, BootErr
    );

endinterface

// File: rtl/rvc_boot_word_asm.sv
// Little-endian byte-to-word assembler: 2-bit byte index, 24-bit shift register
// holding the first three bytes, and a combinational word-complete pulse.
module rvc_boot_word_asm
    import rvc_asap_pkg::*;
(
    input  logic        Clock,
    input  logic        Rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    localparam logic [1:0] LAST_IDX = 2'(BOOT_HDR_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (accept_i) begin
            idx_d   = idx_q + 2'd1;
            shreg_d = {byte_i, shreg_q[23:8]};
        end
    end

    // The 4th byte completes the word in the same cycle it is accepted.
    assign word_o = {byte_i, shreg_q};
    assign done_o = accept_i && !clear_i && (idx_q == LAST_IDX);

    always_ff @(posedge Clock or negedge Rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/rvc_boot_loader.sv
// Boot loader: streams a length-prefixed image into I_MEM, then releases CoreRst.
// Optional trailing checksum word is enabled by defining RVC_BOOT_CHECKSUM_EN.
module rvc_boot_loader
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 4096,
    parameter int          RELEASE_DLY = 4
) (
    input  logic             Clock,
    input  logic             Rst,
    rvc_boot_loader_if.slave bus
);

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);
    localparam logic [31:0] DLY_LAST    = (RELEASE_DLY > 0) ? 32'(RELEASE_DLY - 1) : 32'd0;
`ifdef RVC_BOOT_CHECKSUM_EN
    localparam t_boot_state END_STATE = CSUM;
`else
    localparam t_boot_state END_STATE = WAIT;
`endif

    t_boot_state state_q, state_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
`ifdef RVC_BOOT_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        byte_ready, core_rst, boot_done, boot_err;
    logic        accept, restart, asm_done;
    logic [31:0] asm_word;

    assign accept  = bus.ByteValid && byte_ready;
    assign restart = bus.BootRestart && (state_q == RUN || state_q == ERR);

    rvc_boot_word_asm u_word_asm (
        .Clock    (Clock),
        .Rst      (Rst),
        .clear_i  (restart),
        .accept_i (accept),
        .byte_i   (bus.ByteIn),
        .word_o   (asm_word),
        .done_o   (asm_done)
    );

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q    <= HDR;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            wait_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef RVC_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef RVC_BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        wait_cnt_d = wait_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef RVC_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            HDR: if (asm_done) begin
                word_cnt_d = asm_word;
                if (asm_word > MAX_WORDS_W) state_d = ERR;
                else if (asm_word == '0)    state_d = END_STATE;
                else                        state_d = DATA;
            end
            DATA: if (asm_done) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = IMEM_BASE + (word_idx_q << 2);
                wr_data_d  = asm_word;
                word_idx_d = word_idx_q + 32'd1;
`ifdef RVC_BOOT_CHECKSUM_EN
                csum_d     = csum_q + asm_word;
`endif
                if (word_idx_q == word_cnt_q - 32'd1) state_d = END_STATE;
            end
`ifdef RVC_BOOT_CHECKSUM_EN
            CSUM: if (asm_done) state_d = (asm_word == csum_q) ? WAIT : ERR;
`endif
            // The first WAIT cycle coincides with the final write pulse.
            WAIT: begin
                if (wait_cnt_q >= DLY_LAST) state_d = RUN;
                else                        wait_cnt_d = wait_cnt_q + 32'd1;
            end
            RUN, ERR: if (restart) begin
                state_d    = HDR;
                word_cnt_d = '0;
                word_idx_d = '0;
                wait_cnt_d = '0;
`ifdef RVC_BOOT_CHECKSUM_EN
                csum_d     = '0;
`endif
            end
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        core_rst   = 1'b1;
        boot_done  = 1'b0;
        boot_err   = 1'b0;
        case (state_q)
            HDR, DATA: byte_ready = 1'b1;
`ifdef RVC_BOOT_CHECKSUM_EN
            CSUM:      byte_ready = 1'b1;
`endif
            RUN: begin
                core_rst  = 1'b0;
                boot_done = 1'b1;
            end
            ERR:       boot_err = 1'b1;
            default:   ;
        endcase
    end

    assign bus.ByteReady  = byte_ready;
    assign bus.ImemWrEn   = wr_en_q;
    assign bus.ImemWrAddr = wr_addr_q;
    assign bus.ImemWrData = wr_data_q;
    assign bus.CoreRst    = core_rst;
    assign bus.BootDone   = boot_done;
    assign bus.BootErr    = boot_err;

endmodule

// File: tb/tb_rvc_boot_loader.sv
// Scoreboard bench for rvc_boot_loader: stream tasks push expected writes and
// release times; a negedge monitor pops and compares them.
module tb_rvc_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 16;
    localparam int DLY  = 4;
    localparam int PER  = 10;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        longint      t;
    } wr_t;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;

    rvc_boot_loader_if bif();

    rvc_boot_loader #(
        .IMEM_BASE   (BASE),
        .MAX_WORDS   (MAXW),
        .RELEASE_DLY (DLY)
    ) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bif)
    );

    always #(PER/2) Clock = ~Clock;

    int          n_chk  = 0;
    int          n_pass = 0;
    wr_t         exp_wr[$];
    longint      exp_done[$];
    logic [31:0] img[$];
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write and every BootDone rise must match a queued expectation.
    always @(negedge Clock) begin
        wr_t e;
        if (bif.ImemWrEn === 1'b1) begin
            check("write_expected", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", bif.ImemWrAddr, e.addr);
                check("wr_data", bif.ImemWrData, e.data);
                check("wr_time", 64'($time), 64'(e.t));
            end
        end
        if (bif.BootDone === 1'b1 && done_prev !== 1'b1) begin
            check("done_expected", 64'(exp_done.size() > 0), 64'd1);
            if (exp_done.size() > 0) check("release_time", 64'($time), 64'(exp_done.pop_front()));
        end
        done_prev <= bif.BootDone;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap, output longint t_acc);
        int tries;
        @(negedge Clock);
        if (gap) begin
            bif.ByteValid = 1'b0;
            @(negedge Clock);
        end
        bif.ByteIn    = b;
        bif.ByteValid = 1'b1;
        tries = 0;
        while (bif.ByteReady !== 1'b1 && tries < 50) begin
            @(negedge Clock);
            tries++;
        end
        if (tries >= 50) check("ready_timeout", 64'(bif.ByteReady), 64'd1);
        @(posedge Clock);
        t_acc = $time;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_mode, output longint t_acc);
        bit          gap;
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
            sh  = w >> (8 * i);
            send_byte(sh[7:0], gap, t_acc);
        end
    endtask

    task automatic fill(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Reference model: header word, data words, optional checksum; outcome by the boot rules.
    task automatic run_stream(input logic [31:0] hdr, input int gap_mode, input bit corrupt);
        logic [31:0] sum;
        longint      t;
        bit          ok;
        int          n;
        sum = '0;
        ok  = (hdr <= MAXW);
        send_word(hdr, gap_mode, t);
        if (ok) begin
            for (int k = 0; k < int'(hdr); k++) begin
                send_word(img[k], gap_mode, t);
                exp_wr.push_back('{BASE + 32'(4 * k), img[k], t + PER/2});
                sum = sum + img[k];
            end
`ifdef RVC_BOOT_CHECKSUM_EN
            send_word(corrupt ? sum + 32'd1 : sum, gap_mode, t);
            if (corrupt) ok = 1'b0;
`else
            if (corrupt) sum = '0;
`endif
        end
        if (ok) exp_done.push_back(t + DLY * PER + PER/2);
        @(negedge Clock);
        check("ready_after_stream", 64'(bif.ByteReady), 64'd0);
        bif.ByteIn    = 8'($urandom);
        bif.ByteValid = 1'b1;
        n = 0;
        while (bif.BootDone !== 1'b1 && bif.BootErr !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        bif.ByteValid = 1'b0;
        check("boot_done", 64'(bif.BootDone), 64'(ok));
        check("boot_err",  64'(bif.BootErr),  64'(!ok));
        check("core_rst",  64'(bif.CoreRst),  64'(!ok));
        check("writes_pending", 64'(exp_wr.size()), 64'd0);
        check("done_pending",   64'(exp_done.size()), 64'd0);
    endtask

    task automatic restart();
        @(negedge Clock);
        bif.BootRestart = 1'b1;
        @(negedge Clock);
        bif.BootRestart = 1'b0;
        check("restart_core_rst", 64'(bif.CoreRst), 64'd1);
        check("restart_ready",    64'(bif.ByteReady), 64'd1);
        check("restart_done",     64'(bif.BootDone), 64'd0);
        check("restart_err",      64'(bif.BootErr), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"},   64'(bif.ImemWrEn), 64'd0);
        check({tag, "_wr_addr"}, 64'(bif.ImemWrAddr), 64'd0);
        check({tag, "_wr_data"}, 64'(bif.ImemWrData), 64'd0);
        check({tag, "_core_rst"}, 64'(bif.CoreRst), 64'd1);
        check({tag, "_done"},    64'(bif.BootDone), 64'd0);
        check({tag, "_err"},     64'(bif.BootErr), 64'd0);
        check({tag, "_ready"},   64'(bif.ByteReady), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint      t;
        int unsigned n;
        bif.ByteIn      = '0;
        bif.ByteValid   = 1'b0;
        bif.BootRestart = 1'b0;
        #1;
        check_reset_values("por");
        repeat (2) @(negedge Clock);
        Rst = 1'b1;

        // Two-word reference image.
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0010_0093);
        run_stream(32'd2, 0, 1'b0);

        // Oversized header, then empty image.
        restart();
        run_stream(32'(MAXW + 1), 0, 1'b0);
        restart();
        run_stream(32'd0, 0, 1'b0);

        // Same 3-word image with ByteValid toggling, then gap-free.
        restart();
        fill(3);
        run_stream(32'd3, 1, 1'b0);
        restart();
        run_stream(32'd3, 0, 1'b0);

        // Largest legal image with random gaps.
        restart();
        fill(MAXW);
        run_stream(32'(MAXW), 2, 1'b0);

`ifdef RVC_BOOT_CHECKSUM_EN
        restart();
        fill(2);
        run_stream(32'd2, 0, 1'b1);
        restart();
        run_stream(32'd2, 0, 1'b0);
`endif

        // Reset after word 1 of 3, then a fresh 1-word image.
        restart();
        fill(3);
        send_word(32'd3, 0, t);
        for (int k = 0; k < 2; k++) begin
            send_word(img[k], 0, t);
            exp_wr.push_back('{BASE + 32'(4 * k), img[k], t + PER/2});
        end
        @(negedge Clock);
        @(negedge Clock);
        #2 Rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        check("mid_rst_writes_pending", 64'(exp_wr.size()), 64'd0);
        bif.ByteValid = 1'b0;
        @(negedge Clock);
        Rst = 1'b1;
        fill(1);
        run_stream(32'd1, 0, 1'b0);

        // Randomized images.
        for (int r = 0; r < 8; r++) begin
            restart();
            n = $urandom_range(0, MAXW + 1);
            fill((n > MAXW) ? 0 : int'(n));
            run_stream(32'(n), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge Clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rvc_boot_loader.md
RVC_BOOT_LOADER -- requirements
Module: rvc_boot_loader

Interface
REQ-001 The block SHALL have parameter IMEM_BASE, default 32'h0000_0000, the byte address of the first I_MEM word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 4096, the maximum image length in 32-bit words.
REQ-003 The block SHALL have parameter RELEASE_DLY, default 4, the number of cycles between the last I_MEM write and CoreRst deassertion.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: port Clock (input, 1) is the single clock; port Rst (input, 1) is the asynchronous active-low reset.
REQ-005 ByteIn  input  8  next byte of the boot stream.
REQ-006 ByteValid  input  1  ByteIn is valid.
REQ-007 ByteReady  output  1  the loader accepts ByteIn this cycle.
REQ-008 BootRestart  input  1  single-cycle request to reload; honoured only in RUN or ERR.
REQ-009 ImemWrEn  output  1  I_MEM word write strobe.
REQ-010 ImemWrAddr  output  32  I_MEM byte address, word-aligned.
REQ-011 ImemWrData  output  32  I_MEM write data.
REQ-012 CoreRst  output  1  active-high reset driven to the core/memory top-level Rst.
REQ-013 BootDone  output  1  image loaded and core released.
REQ-014 BootErr  output  1  the header or checksum was rejected.

Function
REQ-015 A byte SHALL be accepted exactly on cycles where ByteValid && ByteReady; ByteReady SHALL be 1 only in states HDR, DATA and CSUM.
REQ-016 The FSM states SHALL be HDR, DATA, CSUM, WAIT, RUN and ERR.
REQ-017 HDR SHALL take 4 bytes, little-endian, as the 32-bit WordCnt.
REQ-018 After the 4th HDR byte: if WordCnt > MAX_WORDS, go to ERR; if WordCnt == 0, go to CSUM when the macro is defined and to WAIT otherwise; else go to DATA.
REQ-019 DATA SHALL assemble bytes little-endian with a 2-bit byte index that wraps 3->0.
REQ-020 On each 4th byte, the block SHALL assert ImemWrEn for exactly one cycle on the following cycle, with ImemWrAddr = IMEM_BASE + 4*k (k = word index from 0) and ImemWrData = the assembled word.
REQ-021 ImemWrAddr SHALL be word-aligned, using a 32-bit modulo add.
REQ-022 After word WordCnt-1 is accepted, DATA SHALL go to CSUM (macro defined) or WAIT (macro undefined).
REQ-023 WAIT SHALL count RELEASE_DLY cycles, starting after the final ImemWrEn pulse, then go to RUN.
REQ-024 CoreRst SHALL be 1 in all states except RUN.
REQ-025 BootDone SHALL be 1 only in RUN; BootErr SHALL be 1 only in ERR.
REQ-026 RUN or ERR with BootRestart=1 SHALL go to HDR on the next edge, clear all counters, and make CoreRst=1 in that same next cycle.
REQ-027 ERR SHALL be left only by BootRestart or Rst.
REQ-028 Bytes presented while ByteReady=0 SHALL be ignored and SHALL not be consumed.

Reset
REQ-029 When Rst=0, the block SHALL asynchronously set state=HDR, all counters=0, ImemWrEn=0, ImemWrAddr=0, ImemWrData=0, CoreRst=1, BootDone=0 and BootErr=0.
REQ-030 Rst asserted mid-DATA SHALL abandon the image; no further I_MEM writes SHALL occur.
REQ-031 The first accept after reset release SHALL be byte 0 of HDR.

Configuration
REQ-032 With RVC_BOOT_CHECKSUM_EN defined, CSUM SHALL take 4 little-endian bytes.
REQ-033 With RVC_BOOT_CHECKSUM_EN defined, the block SHALL go to WAIT if those bytes equal the mod-2^32 sum of all data words (0 for an empty image), and to ERR otherwise.
REQ-034 With RVC_BOOT_CHECKSUM_EN undefined, the CSUM state and the accumulator SHALL be absent, and the stream SHALL end after the last data word.

Structure
REQ-035 The shared package rvc_asap_pkg SHALL hold the state enum t_boot_state and the byte-count constant BOOT_HDR_BYTES=4.
REQ-036 Byte-to-word assembly (the byte index, the shift register and the word-complete pulse) SHALL be the sub-module rvc_boot_word_asm.

Verification
REQ-037 Stream hdr=2, words 32'h0000_0013, 32'h0010_0093 (checksum 32'h0010_00A6 when the macro is defined) -> writes at 0x0 and 0x4 with those data; CoreRst falls RELEASE_DLY cycles after the 2nd write; BootDone=1.
REQ-038 hdr=MAX_WORDS+1 -> ERR, BootErr=1, no ImemWrEn, CoreRst stays 1.
REQ-039 hdr=0 -> no writes; RUN is reached after RELEASE_DLY cycles (plus 4 checksum bytes of 0 when the macro is defined).
REQ-040 ByteValid toggling 1/0 every cycle, 3 words -> identical writes to the gap-free stream.
REQ-041 Rst pulled low after word 1 of 3, then a new 1-word stream -> exactly one write, at IMEM_BASE.
REQ-042 With the macro defined, a bad checksum -> ERR; then BootRestart plus a valid stream -> RUN with CoreRst low.
